// File: rtl/hdmi_tdms_dec.sv
// TMDS channel decoder with word-alignment FSM (search / bitslip / settle / locked).
// Define HDMI_TDMS_DEC_ERRCNT_EN to add the err_cnt invalid-symbol counter.
module hdmi_tdms_dec #(
  parameter int LOCK_TOKENS    = 16,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 8,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic        clk_pix,
  input  logic        arst,
  input  logic [9:0]  sym_in,
  output logic        bitslip,
  output logic        locked,
  output logic        de,
  output logic [1:0]  c,
  output logic [7:0]  d
`ifdef HDMI_TDMS_DEC_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int CYC_W = 13;
  localparam int TOK_W = $clog2(LOCK_TOKENS + 1);
  localparam logic [CYC_W-1:0] CYC_MAX     = '1;
  localparam logic [CYC_W-1:0] SEARCH_LAST = CYC_W'(SEARCH_TIMEOUT - 1);
  localparam logic [CYC_W-1:0] WAIT_LAST   = CYC_W'(SLIP_WAIT - 1);
  localparam logic [CYC_W-1:0] LOSS_LAST   = CYC_W'(LOSS_TIMEOUT - 1);
  localparam logic [TOK_W-1:0] TOK_MAX     = '1;
  localparam logic [TOK_W-1:0] TOK_LAST    = TOK_W'(LOCK_TOKENS - 1);

  typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d, cyc_inc;
  logic [TOK_W-1:0]  tok_q, tok_d, tok_inc;
  logic [9:0]        sym_q;
  logic              de_q, de_d;
  logic [1:0]        c_q, c_d;
  logic [7:0]        pix_q, pix_d;

  logic              is_tok;
  logic [1:0]        tok_c;
  logic [7:0]        q_bits, dec_byte;

  always_comb begin
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (sym_q)
      10'b1101010100: tok_c = 2'b00;
      10'b0010101011: tok_c = 2'b01;
      10'b0101010100: tok_c = 2'b10;
      10'b1010101011: tok_c = 2'b11;
      default:        is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion, then undo the XOR/XNOR chaining bit by bit.
  assign q_bits      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
  assign dec_byte[0] = q_bits[0];
  generate
    for (genvar gi = 1; gi < 8; gi++) begin : g_dec
      assign dec_byte[gi] = sym_q[8] ? (q_bits[gi] ^ q_bits[gi-1])
                                     : ~(q_bits[gi] ^ q_bits[gi-1]);
    end
  endgenerate

  assign cyc_inc = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + 1'b1;
  assign tok_inc = (tok_q == TOK_MAX) ? tok_q : tok_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    tok_d   = tok_q;
    case (state_q)
      SEARCH: begin
        // A token on the timeout cycle takes precedence over the slip.
        if (is_tok) begin
          cyc_d = '0;
          tok_d = tok_inc;
          if (tok_q >= TOK_LAST) begin
            state_d = LOCKED;
            tok_d   = '0;
          end
        end else begin
          tok_d = '0;
          cyc_d = cyc_inc;
          if (cyc_q >= SEARCH_LAST) begin
            state_d = SLIP;
            cyc_d   = '0;
          end
        end
      end
      SLIP: begin
        state_d = WAIT;
        cyc_d   = '0;
        tok_d   = '0;
      end
      WAIT: begin
        cyc_d = cyc_inc;
        if (cyc_q >= WAIT_LAST) begin
          state_d = SEARCH;
          cyc_d   = '0;
          tok_d   = '0;
        end
      end
      LOCKED: begin
        if (is_tok) begin
          cyc_d = '0;
        end else begin
          cyc_d = cyc_inc;
          if (cyc_q >= LOSS_LAST) begin
            state_d = SEARCH;
            cyc_d   = '0;
            tok_d   = '0;
          end
        end
      end
      default: begin
        state_d = SEARCH;
        cyc_d   = '0;
        tok_d   = '0;
      end
    endcase
  end

  always_comb begin
    de_d  = ~is_tok;
    c_d   = is_tok ? tok_c : c_q;
    pix_d = is_tok ? pix_q : dec_byte;
  end

  always_ff @(posedge clk_pix or posedge arst) begin
    if (arst) begin
      state_q <= SEARCH;
      cyc_q   <= '0;
      tok_q   <= '0;
      sym_q   <= '0;
      de_q    <= 1'b0;
      c_q     <= 2'b00;
      pix_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      tok_q   <= tok_d;
      sym_q   <= sym_in;
      de_q    <= de_d;
      c_q     <= c_d;
      pix_q   <= pix_d;
    end
  end

  assign locked  = (state_q == LOCKED);
  assign bitslip = (state_q == SLIP);
  assign de      = de_q & locked;
  assign c       = c_q;
  assign d       = pix_q;

`ifdef HDMI_TDMS_DEC_ERRCNT_EN
  logic [15:0] err_q, err_d;
  logic [6:0]  trans_bits;
  logic [3:0]  trans_cnt;

  assign trans_bits = sym_q[7:1] ^ sym_q[6:0];

  always_comb begin
    trans_cnt = '0;
    for (int i = 0; i < 7; i++) begin
      trans_cnt = trans_cnt + {3'b000, trans_bits[i]};
    end
  end

  // Valid data symbols never exceed 4 transitions in their low byte.
  always_comb begin
    err_d = err_q;
    if (state_q != LOCKED && state_d == LOCKED) begin
      err_d = '0;
    end else if (state_q == LOCKED && !is_tok && trans_cnt > 4'd4 && err_q != 16'hFFFF) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clk_pix or posedge arst) begin
    if (arst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule
